host_image_streamer: RTL
========================

// Module: host_image_streamer
// PURPOSE
//  Host-side end of the board's UART memory-load/readback link. Streams an instruction image, then a data
//  image, from a local source memory to a UART transmitter byte interface. Then collects the returned
//  result words from the UART receiver byte interface and writes them into a result memory.
//  Used as the loader in board-to-board setups and as the synthesizable host model in system benches.
// PARAMETERS
//  INS_WIDTH       8   instruction word width (bits)
//  DATA_WIDTH      48  data/result word width (bits)
//  UART_WIDTH      8   byte width of the UART byte interface
//  ADDR_WIDTH      12  source/result address width; also the width of the word counts
//  INS_BYTES  (derived) ceil(INS_WIDTH/UART_WIDTH); DATA_BYTES (derived) ceil(DATA_WIDTH/UART_WIDTH)
// PORTS
//  clk          in   1           system clock
//  rstN         in   1           asynchronous active-low reset
//  start        in   1           1-cycle pulse; begins a transfer session (ignored while busy)
//  ins_count    in   ADDR_WIDTH  instruction words to send (latched at start)
//  data_count   in   ADDR_WIDTH  data words to send (latched at start)
//  result_count in   ADDR_WIDTH  result words to receive (latched at start)
//  src_sel      out  1           0 = instruction image, 1 = data image
//  src_addr     out  ADDR_WIDTH  source memory word address
//  src_data     in   DATA_WIDTH  source read data; synchronous, valid 1 cycle after src_addr/src_sel
//  txByteStart  out  1           1-cycle pulse: transmit byteForTx
//  byteForTx    out  UART_WIDTH  byte to transmit; stable from the start pulse until the next pulse
//  txByteReady  in   1           transmitter idle
//  rx_new_byte_indicate in 1     1-cycle pulse: byteFromRx is valid
//  byteFromRx   in   UART_WIDTH  received byte
//  res_wrEn     out  1           1-cycle result memory write strobe
//  res_addr     out  ADDR_WIDTH  result word address (0-based)
//  res_data     out  DATA_WIDTH  assembled result word
//  busy         out  1           session in progress
//  done         out  1           session complete; held until the next accepted start or reset
// BEHAVIOUR
//  Reset (async, rstN=0): all outputs 0; FSM=IDLE; counters and shift registers cleared.
//  FSM: IDLE -> INS_FETCH -> INS_SEND -> DATA_FETCH -> DATA_SEND -> RX_COLLECT -> DONE.
//   IDLE/DONE: start=1 latches the counts, sets busy=1 and done=0, and clears src_addr/res_addr.
//   Sections with count 0 are skipped: go to the next non-empty section, or to DONE.
//   *_FETCH: drive src_sel/src_addr for 1 cycle; on the next cycle load src_data into the tx shift register.
//   *_SEND: wait for txByteReady=1, then pulse txByteStart with byteForTx = shreg[UART_WIDTH-1:0].
//    Bytes go least significant first; the top byte is zero-padded.
//    txByteReady is ignored in the cycle after a pulse (guard), then waited for high again.
//    After INS_BYTES/DATA_BYTES bytes: increment src_addr. If the count is reached, advance the section
//    (src_addr resets to 0 for data); otherwise fetch again.
//   The final data byte's start pulse moves the FSM to RX_COLLECT in the next cycle.
//    If result_count=0, it goes instead to DONE, once txByteReady returns high after the guard.
//   RX_COLLECT: each rx_new_byte_indicate loads byteFromRx into the rx assembler (LSB first).
//    After DATA_BYTES bytes: res_data = word; res_wrEn=1 for 1 cycle; res_addr increments after the write.
//    After result_count writes -> DONE. The final write and the done=1 assertion occur in consecutive
//    cycles, with done asserting in the cycle after res_wrEn.
//   DONE: busy=0, done=1.
//  Rx pulses outside RX_COLLECT are dropped and do not advance the assembler. An rx pulse coinciding
//   with the entry cycle into RX_COLLECT is accepted.
//  start while busy is ignored. Simultaneous start and rx pulse in IDLE: start is taken and the byte dropped.
//  Counts are unsigned; max ins_count = 2^ADDR_WIDTH-1. src_addr/res_addr never wrap within a session.
//  Reset mid-session aborts immediately. No partial word is written, and no further txByteStart is issued.
// TESTING
//  1 ins_count=3 (A1,B2,C3), data_count=1 (0x060504030201), result_count=0, txByteReady always 1 ->
//    tx A1 B2 C3 01 02 03 04 05 06 in order; done=1; no res_wrEn.
//  2 result_count=2, all counts 0 except result, rx bytes 0x11..0x1C -> writes
//    addr0=0x161514131211, addr1=0x1C1B1A191817; done in the cycle after the 2nd write.
//  3 txByteReady held 0 for 50 cycles mid-INS_SEND -> no start pulses, byteForTx stable; resumes in order.
//  4 rstN low during DATA_SEND byte 3 -> all outputs 0 asynchronously; after release, IDLE with no tx activity.
//  5 start pulsed during INS_SEND and rx bytes injected during DATA_SEND -> both ignored;
//    result words unaffected (compare against scenario 2).
//  6 all counts 0, start -> busy pulses, done=1 within 2 cycles, no tx/res activity.

Source files
------------

// File: rtl/host_image_streamer.sv
// Host side of the UART load/readback link: streams instruction then data words LSB-byte first,
// then assembles returned result words. Each tx byte waits for txByteReady; rx bytes are never stalled.
module host_image_streamer #(
  parameter int INS_WIDTH  = 8,
  parameter int DATA_WIDTH = 48,
  parameter int UART_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] ins_count,
  input  logic [ADDR_WIDTH-1:0] data_count,
  input  logic [ADDR_WIDTH-1:0] result_count,
  output logic                  src_sel,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  txByteStart,
  output logic [UART_WIDTH-1:0] byteForTx,
  input  logic                  txByteReady,
  input  logic                  rx_new_byte_indicate,
  input  logic [UART_WIDTH-1:0] byteFromRx,
  output logic                  res_wrEn,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic                  done
);
  localparam int INS_BYTES  = (INS_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int DATA_BYTES = (DATA_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int SHW        = DATA_BYTES * UART_WIDTH;
  localparam int BCW        = $clog2(DATA_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, INS_FETCH, INS_SEND, DATA_FETCH, DATA_SEND, RX_COLLECT, DONE
  } stateT;

  stateT state, nextState;

  logic                  fetchPhase, txTail, guard;
  logic [SHW-1:0]        shreg, rxShreg, rxNext;
  logic [BCW-1:0]        byteCnt, rxByteCnt, nBytesM1;
  logic [ADDR_WIDTH-1:0] insCnt, dataCnt, resCnt, wordsRx, secCnt;
  logic                  isIns, isFetch, lastWord, rxLastWord;
  logic                  startAcc, canSend, lastByte, toData, setTail, rxAcc, rxWordDone;

  assign isIns      = (state == INS_SEND);
  assign isFetch    = (state == INS_FETCH) || (state == DATA_FETCH);
  assign nBytesM1   = isIns ? BCW'(INS_BYTES - 1) : BCW'(DATA_BYTES - 1);
  assign secCnt     = isIns ? insCnt : dataCnt;
  assign lastWord   = ({1'b0, src_addr} + 1'b1) == {1'b0, secCnt};
  assign rxLastWord = ({1'b0, wordsRx} + 1'b1) == {1'b0, resCnt};
  assign rxNext     = {byteFromRx, rxShreg[SHW-1:UART_WIDTH]};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState  = state;
    startAcc   = 1'b0;
    canSend    = 1'b0;
    lastByte   = 1'b0;
    toData     = 1'b0;
    setTail    = 1'b0;
    rxAcc      = 1'b0;
    rxWordDone = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          startAcc = 1'b1;
          if (ins_count != '0)         nextState = INS_FETCH;
          else if (data_count != '0)   nextState = DATA_FETCH;
          else if (result_count != '0) nextState = RX_COLLECT;
          else                         nextState = DONE;
        end
      end
      INS_FETCH:  if (fetchPhase) nextState = INS_SEND;
      DATA_FETCH: if (fetchPhase) nextState = DATA_SEND;
      INS_SEND, DATA_SEND: begin
        // Tail: last byte issued; hand over to rx on the pulse, or finish once the transmitter drains
        if (txTail) begin
          if (resCnt != '0) begin
            if (txByteStart) nextState = RX_COLLECT;
          end else if (!txByteStart && !guard && txByteReady) begin
            nextState = DONE;
          end
        end else if (txByteReady && !txByteStart && !guard) begin
          canSend = 1'b1;
          if (byteCnt == nBytesM1) begin
            lastByte = 1'b1;
            if (!lastWord)                     nextState = isIns ? INS_FETCH : DATA_FETCH;
            else if (isIns && dataCnt != '0) begin
              toData    = 1'b1;
              nextState = DATA_FETCH;
            end else                           setTail = 1'b1;
          end
        end
      end
      RX_COLLECT: begin
        if (rx_new_byte_indicate) begin
          rxAcc = 1'b1;
          if (rxByteCnt == BCW'(DATA_BYTES - 1)) begin
            rxWordDone = 1'b1;
            if (rxLastWord) nextState = DONE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fetchPhase <= 1'b0; txTail <= 1'b0; guard <= 1'b0;
      shreg <= '0; rxShreg <= '0; byteCnt <= '0; rxByteCnt <= '0;
      insCnt <= '0; dataCnt <= '0; resCnt <= '0; wordsRx <= '0;
      src_sel <= 1'b0; src_addr <= '0; txByteStart <= 1'b0; byteForTx <= '0;
      res_wrEn <= 1'b0; res_addr <= '0; res_data <= '0; busy <= 1'b0; done <= 1'b0;
    end else begin
      txByteStart <= canSend;
      guard       <= txByteStart;
      res_wrEn    <= rxWordDone;
      fetchPhase  <= isFetch && !fetchPhase;
      if (isFetch && fetchPhase) begin
        shreg   <= (state == INS_FETCH) ? SHW'(src_data[INS_WIDTH-1:0]) : SHW'(src_data);
        byteCnt <= '0;
      end
      if (canSend) begin
        byteForTx <= shreg[UART_WIDTH-1:0];
        shreg     <= shreg >> UART_WIDTH;
        byteCnt   <= byteCnt + 1'b1;
      end
      if (lastByte) begin
        if (toData) begin
          src_addr <= '0;
          src_sel  <= 1'b1;
        end else begin
          src_addr <= src_addr + 1'b1;
        end
      end
      if (setTail) txTail <= 1'b1;
      if (rxAcc) begin
        rxShreg <= rxNext;
        if (rxWordDone) begin
          rxByteCnt <= '0;
          wordsRx   <= wordsRx + 1'b1;
          res_data  <= rxNext[DATA_WIDTH-1:0];
        end else begin
          rxByteCnt <= rxByteCnt + 1'b1;
        end
      end
      if (res_wrEn) res_addr <= res_addr + 1'b1;
      if (startAcc) begin
        insCnt    <= ins_count;
        dataCnt   <= data_count;
        resCnt    <= result_count;
        src_addr  <= '0;
        src_sel   <= (ins_count == '0);
        res_addr  <= '0;
        wordsRx   <= '0;
        rxByteCnt <= '0;
        rxShreg   <= '0;
        txTail    <= 1'b0;
        busy      <= 1'b1;
        done      <= 1'b0;
      end else if (state == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule
